// File: rtl/cpu_pkg.sv
// Shared encodings for the LDM/STM sequencer: FSM states, word size and
// the {P,U} addressing-mode codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_XFER = 3'd2,
        ST_GAP  = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int WORD_BYTES = 4;

    // Mode codes are the concatenation {P, U}.
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/reg_list_prio_enc.sv
// Lowest-set-bit encoder and population count for a 16-bit register list.
module reg_list_prio_enc (
    input  logic [15:0] list,
    output logic [3:0]  idx,
    output logic        valid,
    output logic [4:0]  count
);

    // Scanning from the top down leaves the lowest set bit as the final winner.
    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        count = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            count = count + {4'b0000, list[i]};
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest index first, moving one word
// per set bit over the MOC handshake, then optionally writes back the base.
module ldm_stm_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              load,
    input  logic              pre,
    input  logic              up,
    input  logic              wback,
    input  logic [3:0]        base_reg,
    input  logic [31:0]       base_val,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic [3:0]        rf_rd_sel,
    input  logic [31:0]       rf_rd_data,
    output logic              rf_wr_en,
    output logic [3:0]        rf_wr_sel,
    output logic [31:0]       rf_wr_data,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_moc
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    state_t            state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]       base_q, base_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic              load_q, load_d;
    logic              pre_q, pre_d;
    logic              up_q, up_d;
    logic              wback_q, wback_d;
    logic              base_hit_q, base_hit_d;

    logic [3:0]        enc_idx;
    logic              enc_valid;
    logic [4:0]        enc_count;
    logic [ADDR_W-1:0] base_lo;
    logic [ADDR_W-1:0] word_step;
    logic [ADDR_W-1:0] four_n;

    reg_list_prio_enc u_enc (
        .list  (list_q),
        .idx   (enc_idx),
        .valid (enc_valid),
        .count (enc_count)
    );

    assign base_lo   = base_q[ADDR_W-1:0];
    assign word_step = ADDR_W'(WORD_BYTES);
    assign four_n    = ADDR_W'(enc_count) << $clog2(WORD_BYTES);

    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        addr_d     = addr_q;
        wb_addr_d  = wb_addr_q;
        base_d     = base_q;
        base_reg_d = base_reg_q;
        load_d     = load_q;
        pre_d      = pre_q;
        up_d       = up_q;
        wback_d    = wback_q;
        base_hit_d = base_hit_q;

        busy       = 1'b0;
        done       = 1'b0;
        rf_rd_sel  = 4'd0;
        rf_wr_en   = 1'b0;
        rf_wr_sel  = 4'd0;
        rf_wr_data = 32'd0;
        mem_req    = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_d     = load;
                    pre_d      = pre;
                    up_d       = up;
                    wback_d    = wback;
                    base_reg_d = base_reg;
                    base_d     = base_val;
                    list_d     = reg_list;
                    state_d    = ST_CALC;
                end
            end

            ST_CALC: begin
                busy       = 1'b1;
                base_hit_d = list_q[base_reg_q];
                wb_addr_d  = up_q ? (base_lo + four_n) : (base_lo - four_n);
                // Every mode walks upward, so decrementing modes start at the low end of the block.
                case ({pre_q, up_q})
                    MODE_DA: addr_d = base_lo - four_n + word_step;
                    MODE_IA: addr_d = base_lo;
                    MODE_DB: addr_d = base_lo - four_n;
                    default: addr_d = base_lo + word_step;
                endcase
                state_d = enc_valid ? ST_XFER : ST_DONE;
            end

            ST_XFER: begin
                busy      = 1'b1;
                rf_rd_sel = enc_idx;
                mem_req   = 1'b1;
                mem_rw    = load_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = load_q ? 32'd0 : rf_rd_data;
                if (mem_moc) begin
                    if (load_q) begin
                        rf_wr_en   = 1'b1;
                        rf_wr_sel  = enc_idx;
                        rf_wr_data = mem_rdata;
                    end
                    list_d  = list_q & ~(16'h0001 << enc_idx);
                    addr_d  = addr_q + word_step;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                busy    = 1'b1;
                state_d = enc_valid ? ST_XFER : ST_WB;
            end

            ST_WB: begin
                busy = 1'b1;
                // A base register that was just loaded keeps the loaded word.
                if (wback_q && !(load_q && base_hit_q)) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_sel  = base_reg_q;
                    rf_wr_data = (base_q & ~ADDR_MASK) | 32'(wb_addr_q);
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            list_q     <= 16'd0;
            addr_q     <= '0;
            wb_addr_q  <= '0;
            base_q     <= 32'd0;
            base_reg_q <= 4'd0;
            load_q     <= 1'b0;
            pre_q      <= 1'b0;
            up_q       <= 1'b0;
            wback_q    <= 1'b0;
            base_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            wb_addr_q  <= wb_addr_d;
            base_q     <= base_d;
            base_reg_q <= base_reg_d;
            load_q     <= load_d;
            pre_q      <= pre_d;
            up_q       <= up_d;
            wback_q    <= wback_d;
            base_hit_q <= base_hit_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: register-file and RAM models with programmable
// MOC latency, a table of LDM/STM cases, and a mid-transfer reset sequence.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        load;
    logic        pre;
    logic        up;
    logic        wback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic        busy;
    logic        done;
    logic [3:0]  rf_rd_sel;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_sel;
    logic [31:0] rf_wr_data;
    logic        mem_req;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic        load;
        logic        pre;
        logic        up;
        logic        wback;
        logic [3:0]  base_reg;
        logic [31:0] base_val;
        logic [15:0] reg_list;
        int          moc_lat;
        int          exp_n;
        logic [7:0]  exp_addr0;
        logic        exp_wb;
        logic [31:0] exp_wb_val;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic        rw;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } rfw_t;

    logic [31:0] rf  [16];
    logic [31:0] ram [64];
    xfer_t       xfer_log [$];
    rfw_t        rfw_log  [$];
    int          moc_lat  = 1;
    int          moc_cnt  = 0;
    int          done_cnt = 0;
    vec_t        vecs [8];

    always #5 clk = ~clk;

    ldm_stm_sequencer #(.ADDR_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .load       (load),
        .pre        (pre),
        .up         (up),
        .wback      (wback),
        .base_reg   (base_reg),
        .base_val   (base_val),
        .reg_list   (reg_list),
        .busy       (busy),
        .done       (done),
        .rf_rd_sel  (rf_rd_sel),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_sel  (rf_wr_sel),
        .rf_wr_data (rf_wr_data),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_moc    (mem_moc)
    );

    assign rf_rd_data = rf[rf_rd_sel];

    // RAM: raises MOC moc_lat cycles after the request first appears, for one cycle.
    always @(posedge clk) begin
        if (clr) begin
            mem_moc   <= 1'b0;
            mem_rdata <= 32'd0;
            moc_cnt   <= 0;
        end else if (mem_moc) begin
            mem_moc <= 1'b0;
            moc_cnt <= 0;
        end else if (mem_req) begin
            if (moc_cnt + 1 >= moc_lat) begin
                mem_moc   <= 1'b1;
                mem_rdata <= ram[mem_addr[7:2]];
                if (!mem_rw) ram[mem_addr[7:2]] <= mem_wdata;
            end else begin
                moc_cnt <= moc_cnt + 1;
            end
        end else begin
            moc_cnt <= 0;
        end
    end

    // Register-file write port and transaction logging.
    always @(posedge clk) begin
        if (!clr && mem_req && mem_moc)
            xfer_log.push_back('{mem_addr, mem_rw, mem_wdata});
        if (!clr && rf_wr_en) begin
            rfw_log.push_back('{rf_wr_sel, rf_wr_data});
            rf[rf_wr_sel] <= rf_wr_data;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"},       32'(busy),       32'd0);
        checkOutput({pfx, "_done"},       32'(done),       32'd0);
        checkOutput({pfx, "_mem_req"},    32'(mem_req),    32'd0);
        checkOutput({pfx, "_mem_rw"},     32'(mem_rw),     32'd0);
        checkOutput({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
        checkOutput({pfx, "_mem_wdata"},  mem_wdata,       32'd0);
        checkOutput({pfx, "_rf_wr_en"},   32'(rf_wr_en),   32'd0);
        checkOutput({pfx, "_rf_wr_sel"},  32'(rf_wr_sel),  32'd0);
        checkOutput({pfx, "_rf_wr_data"}, rf_wr_data,      32'd0);
        checkOutput({pfx, "_rf_rd_sel"},  32'(rf_rd_sel),  32'd0);
    endtask

    function automatic logic [31:0] ramInit(input int w);
        return 32'hC0DE_0000 + 32'(w);
    endfunction

    function automatic logic [31:0] rfInit(input int r);
        return 32'h0101_0101 * 32'(r + 1);
    endfunction

    task automatic preload(input logic [3:0] breg, input logic [31:0] bval, input int lat);
        for (int i = 0; i < 16; i++) rf[i] = rfInit(i);
        rf[breg] = bval;
        for (int w = 0; w < 64; w++) ram[w] = ramInit(w);
        moc_lat = lat;
        xfer_log.delete();
        rfw_log.delete();
    endtask

    task automatic driveStart(input logic l, input logic p, input logic u, input logic w,
                              input logic [3:0] breg, input logic [31:0] bval, input logic [15:0] lst);
        @(negedge clk);
        load     = l;
        pre      = p;
        up       = u;
        wback    = w;
        base_reg = breg;
        base_val = bval;
        reg_list = lst;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        load     = ~l;
        pre      = ~p;
        up       = ~u;
        base_reg = ~breg;
        base_val = 32'hDEAD_BEEF;
        reg_list = 16'hFFFF;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rf_snap [16];
        int          cycles;
        bit          got_done;
        int          k;
        int          exp_writes;
        logic [7:0]  ea;

        preload(v.base_reg, v.base_val, v.moc_lat);
        for (int i = 0; i < 16; i++) rf_snap[i] = rf[i];
        driveStart(v.load, v.pre, v.up, v.wback, v.base_reg, v.base_val, v.reg_list);

        cycles   = 1;
        got_done = 1'b0;
        checkOutput({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
        while (!got_done && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) got_done = 1'b1;
        end
        checkOutput({v.name, "_done_seen"}, 32'(got_done), 32'd1);
        checkOutput({v.name, "_cycles"}, 32'(cycles), 32'(v.exp_cycles));
        checkOutput({v.name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_done_pulse"}, 32'(done), 32'd0);

        checkOutput({v.name, "_xfer_count"}, 32'(xfer_log.size()), 32'(v.exp_n));
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (v.reg_list[r]) begin
                ea = v.exp_addr0 + 8'(4 * k);
                if (k < xfer_log.size()) begin
                    checkOutput({v.name, "_addr"}, 32'(xfer_log[k].addr), 32'(ea));
                    checkOutput({v.name, "_rw"}, 32'(xfer_log[k].rw), 32'(v.load));
                    if (!v.load)
                        checkOutput({v.name, "_store_data"}, xfer_log[k].wdata, rf_snap[r]);
                end
                if (v.load && k < rfw_log.size()) begin
                    checkOutput({v.name, "_load_sel"}, 32'(rfw_log[k].sel), 32'(r));
                    checkOutput({v.name, "_load_data"}, rfw_log[k].data, ramInit(int'(ea[7:2])));
                end
                k++;
            end
        end

        exp_writes = (v.load ? v.exp_n : 0) + (v.exp_wb ? 1 : 0);
        checkOutput({v.name, "_rf_writes"}, 32'(rfw_log.size()), 32'(exp_writes));
        if (v.exp_wb && rfw_log.size() == exp_writes && exp_writes > 0) begin
            checkOutput({v.name, "_wb_sel"}, 32'(rfw_log[exp_writes-1].sel), 32'(v.base_reg));
            checkOutput({v.name, "_wb_data"}, rfw_log[exp_writes-1].data, v.exp_wb_val);
        end
    endtask

    initial begin
        int  waited;
        int  done_before;
        int  stamp;

        vecs[0] = '{"stmia",        1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h20, 16'h000A, 2, 2, 8'h20, 1'b1, 32'h28, 11};
        vecs[1] = '{"ldmdb",        1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h40, 16'h0007, 1, 3, 8'h34, 1'b1, 32'h34, 12};
        vecs[2] = '{"empty",        1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h50, 16'h0000, 1, 0, 8'h00, 1'b0, 32'h00, 2};
        vecs[3] = '{"stmib_wrap",   1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 32'hFC, 16'h0020, 1, 1, 8'h00, 1'b1, 32'h00, 6};
        vecs[4] = '{"ldmia_basein", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h10, 16'h0006, 1, 2, 8'h10, 1'b0, 32'h00, 9};
        vecs[5] = '{"stmda",        1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 32'h30, 16'h8001, 1, 2, 8'h2C, 1'b1, 32'h28, 9};
        vecs[6] = '{"stm_basein",   1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  32'h60, 16'h0018, 3, 2, 8'h60, 1'b1, 32'h68, 13};
        vecs[7] = '{"ldmda_now",    1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 32'h20, 16'h0101, 1, 2, 8'h1C, 1'b0, 32'h00, 9};

        clr      = 1'b1;
        start    = 1'b0;
        load     = 1'b0;
        pre      = 1'b0;
        up       = 1'b0;
        wback    = 1'b0;
        base_reg = 4'd0;
        base_val = 32'd0;
        reg_list = 16'd0;
        preload(4'd0, 32'd0, 1);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Abort an LDMIA of three registers while the second request is pending.
        preload(4'd13, 32'h40, 3);
        driveStart(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h40, 16'h0007);
        waited = 0;
        while (!(xfer_log.size() == 1 && mem_req) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_reached_second_req", 32'(waited < 100), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("abort");
        @(negedge clk);
        clr = 1'b0;
        done_before = done_cnt;
        stamp = rfw_log.size();
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_cnt), 32'(done_before));
        checkOutput("abort_no_more_xfer", 32'(xfer_log.size()), 32'd1);
        checkOutput("abort_no_more_rf_write", 32'(rfw_log.size()), 32'(stamp));
        checkOutput("abort_rf_writes_total", 32'(rfw_log.size()), 32'd1);
        checkOutput("abort_idle_mem_req", 32'(mem_req), 32'd0);
        applyStimulus(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
